spi_master: RTL

- SPI Mode 0 master that serialises one 24-bit frame per request: cmd[23:16], addr[15:8], payload[7:0], MSB first.
- Generates sclk, cs (active low) and mosi from the 125 MHz sysclk domain, with timing sized for the SPI slave's synchroniser and mid-bit sampler.
- Optionally captures the 24-bit miso response frame.
- Sits on the controller side of the LED brightness link, driven by a command sequencer.

---
 rtl/spi_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
`default_nettype none
// spi_master: SPI mode 0 master that shifts out one 24-bit {cmd,addr,payload} frame per start.
// Define SPI_MASTER_RX_EN to build the miso synchroniser and 24-bit response capture.
module spi_master #(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 8,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [7:0]  i_addr,
  input  logic [7:0]  i_payload,
  output logic        o_busy,
  output logic        o_done,
  output logic [23:0] o_rx_frame,
  output logic        sclk,
  output logic        cs,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [15:0] HP_LOAD    = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] SETUP_LOAD = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LOAD  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(CS_GAP - 1);

  state_t      state_q;
  logic [15:0] timer_q;
  logic [4:0]  bit_cnt_q;
  logic [22:0] tx_sr_q;
  logic        sclk_q;
  logic        cs_q;
  logic        mosi_q;
  logic        busy_q;
  logic        done_q;
  logic        timer_zero;

  assign timer_zero = (timer_q == 16'd0);

  // The MSB goes straight to mosi at start, so only the remaining 23 bits are kept.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      bit_cnt_q <= 5'd0;
      tx_sr_q   <= 23'd0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      timer_q <= timer_q - 16'd1;
      case (state_q)
        IDLE: begin
          timer_q <= 16'd0;
          if (i_start) begin
            tx_sr_q   <= {i_cmd[6:0], i_addr, i_payload};
            mosi_q    <= i_cmd[7];
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= 5'd0;
            timer_q   <= SETUP_LOAD;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (timer_zero) begin
            sclk_q  <= 1'b1;
            timer_q <= HP_LOAD;
            state_q <= SCLK_HI;
          end
        end
        SCLK_HI: begin
          if (timer_zero) begin
            sclk_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            timer_q   <= HP_LOAD;
            state_q   <= SCLK_LO;
            if (bit_cnt_q == 5'd23) begin
              mosi_q <= 1'b0;
            end else begin
              mosi_q  <= tx_sr_q[22];
              tx_sr_q <= {tx_sr_q[21:0], 1'b0};
            end
          end
        end
        SCLK_LO: begin
          // The 24th pulse keeps its full low phase before the cs hold time starts.
          if (timer_zero) begin
            if (bit_cnt_q == 5'd24) begin
              timer_q <= HOLD_LOAD;
              state_q <= HOLD;
            end else begin
              sclk_q  <= 1'b1;
              timer_q <= HP_LOAD;
              state_q <= SCLK_HI;
            end
          end
        end
        HOLD: begin
          if (timer_zero) begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            timer_q <= GAP_LOAD;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (timer_zero) begin
            busy_q  <= 1'b0;
            timer_q <= 16'd0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          sclk_q  <= 1'b0;
          cs_q    <= 1'b1;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          timer_q <= 16'd0;
        end
      endcase
    end
  end

  assign sclk   = sclk_q;
  assign cs     = cs_q;
  assign mosi   = mosi_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

`ifdef SPI_MASTER_RX_EN
  logic [1:0]  miso_sync_q;
  logic [23:0] rx_sr_q;
  logic [23:0] rx_frame_q;

  // Sample on the last cycle of each high phase, well after the slave drove the bit.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      miso_sync_q <= 2'b00;
      rx_sr_q     <= 24'd0;
      rx_frame_q  <= 24'd0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso};
      if (state_q == IDLE && i_start) begin
        rx_sr_q <= 24'd0;
      end else if (state_q == SCLK_HI && timer_zero) begin
        rx_sr_q <= {rx_sr_q[22:0], miso_sync_q[1]};
      end
      if (state_q == HOLD && timer_zero) begin
        rx_frame_q <= rx_sr_q;
      end
    end
  end

  assign o_rx_frame = rx_frame_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign o_rx_frame  = 24'd0;
`endif

endmodule
`default_nettype wire
